// File: rtl/img_frame_loader.sv
// Collects a pixel stream into one flat frame register, launches it to the CNN
// with a one-cycle pulse and holds it until the CNN reports completion.
// Optional WAIT watchdog: define IMG_FRAME_LOADER_WDOG_EN.
module img_frame_loader #(
  parameter int PIX_W       = 8,
  parameter int NPIX        = 144,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [PIX_W*NPIX-1:0] frame_out,
  output logic                  frame_valid,
  input  logic                  cnn_done,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  if (NPIX < 1 || WDOG_CYCLES < 1) begin : g_bad_params
    $error("img_frame_loader: NPIX and WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PIX_W*NPIX-1:0]   frame_q, frame_d;
  logic                    err_q, err_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        idx;
  logic                    accept;

`ifdef IMG_FRAME_LOADER_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]         wdog_q, wdog_d;
`endif

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    err_d   = err_q;
`ifdef IMG_FRAME_LOADER_WDOG_EN
    wdog_d  = '0;
`endif
    // A start-of-frame pixel always lands at index 0, whatever was collected.
    idx    = pix_sof ? '0 : cnt_q;
    accept = pix_valid & pix_ready_q;

    case (state_q)
      S_FILL: begin
        if (cnn_done) err_d = 1'b1;
        if (accept) begin
          frame_d[PIX_W*idx +: PIX_W] = pix_in;
          if (pix_sof && cnt_q != '0) err_d = 1'b1;
          if (idx == CNT_W'(NPIX - 1)) begin
            cnt_d   = '0;
            state_d = S_LAUNCH;
          end else begin
            cnt_d = idx + 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (cnn_done) err_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnn_done) begin
          state_d = S_FILL;
`ifdef IMG_FRAME_LOADER_WDOG_EN
        end else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_FILL;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      default: state_d = S_FILL;
    endcase

    // Outputs are registered from the next state so they line up with it.
    pix_ready_d   = (state_d == S_FILL);
    frame_valid_d = (state_d == S_LAUNCH);
    busy_d        = (state_d != S_FILL);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the wide frame register is reset too; it drives the CNN input
  // directly and must read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      frame_q       <= '0;
      err_q         <= 1'b0;
      pix_ready_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef IMG_FRAME_LOADER_WDOG_EN
      wdog_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      err_q         <= err_d;
      pix_ready_q   <= pix_ready_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
`ifdef IMG_FRAME_LOADER_WDOG_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign pix_ready   = pix_ready_q;
  assign frame_out   = frame_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_img_frame_loader.sv
// Directed bench for img_frame_loader: a pixel-list model checked every cycle,
// plus hand-computed spot checks for each scenario.
module tb_img_frame_loader;

  localparam int PIX_W = 8;
  localparam int NPIX  = 144;
  localparam int WDOG  = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [PIX_W-1:0]      pix_in = '0;
  logic                  pix_valid = 1'b0;
  logic                  pix_sof = 1'b0;
  logic                  cnn_done = 1'b0;
  logic                  pix_ready;
  logic [PIX_W*NPIX-1:0] frame_out;
  logic                  frame_valid;
  logic                  busy;
  logic                  err;

  int n_cmp  = 0;
  int n_fail = 0;

  img_frame_loader #(.PIX_W(PIX_W), .NPIX(NPIX), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .frame_out(frame_out),
    .frame_valid(frame_valid), .cnn_done(cnn_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Model: the pixels collected so far, whether a launch or a wait is pending.
  logic [PIX_W-1:0] m_frame [NPIX];
  int  m_n       = 0;
  bit  m_launch  = 0;
  bit  m_waiting = 0;
  int  m_wait    = 0;
  bit  m_err     = 0;
  bit  m_ready   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name, input logic [PIX_W*NPIX-1:0] act,
                             input logic [PIX_W*NPIX-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < NPIX; i++) begin
        if (act[PIX_W*i +: PIX_W] !== exp[PIX_W*i +: PIX_W]) begin
          $display("FAIL %s: byte %0d got 0x%0h expected 0x%0h at %0t", name, i,
                   act[PIX_W*i +: PIX_W], exp[PIX_W*i +: PIX_W], $time);
          break;
        end
      end
    end
  endtask

  task automatic model_step();
    bit rdy;
    if (!rst) begin
      foreach (m_frame[i]) m_frame[i] = '0;
      m_n = 0; m_launch = 0; m_waiting = 0; m_wait = 0; m_err = 0; m_ready = 0;
      return;
    end
    rdy = m_ready;
    if (m_launch) begin
      if (cnn_done) m_err = 1;
      m_launch = 0; m_waiting = 1; m_wait = 0;
    end else if (m_waiting) begin
      if (cnn_done) m_waiting = 0;
`ifdef IMG_FRAME_LOADER_WDOG_EN
      else begin
        m_wait++;
        if (m_wait == WDOG) begin m_waiting = 0; m_err = 1; m_n = 0; end
      end
`endif
    end else begin
      if (cnn_done) m_err = 1;
      if (pix_valid && rdy) begin
        if (pix_sof) begin
          if (m_n != 0) m_err = 1;
          m_n = 0;
        end
        m_frame[m_n] = pix_in;
        m_n++;
        if (m_n == NPIX) begin m_n = 0; m_launch = 1; end
      end
    end
    m_ready = !(m_launch || m_waiting);
  endtask

  task automatic compare_all();
    logic [PIX_W*NPIX-1:0] exp;
    for (int i = 0; i < NPIX; i++) exp[PIX_W*i +: PIX_W] = m_frame[i];
    check("pix_ready", pix_ready, m_ready);
    check("frame_valid", frame_valid, m_launch);
    check("busy", busy, m_launch || m_waiting);
    check("err", err, m_err);
    check_frame("frame_out", frame_out, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 0; pix_sof = 0; cnn_done = 0;
    end
  endtask

  task automatic send_pix(input logic [PIX_W-1:0] v, input logic sof);
    int guard = 0;
    @(negedge clk);
    cnn_done = 0;
    while (!pix_ready && guard < 20) begin
      pix_valid = 0;
      @(negedge clk);
      guard++;
    end
    if (!pix_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL pix_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    pix_in = v; pix_valid = 1; pix_sof = sof;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    pix_valid = 0; pix_sof = 0; cnn_done = 1;
    @(negedge clk);
    cnn_done = 0;
  endtask

  // Called right after the last pixel was driven: launch shows one cycle later.
  task automatic expect_launch(input string tag);
    @(negedge clk);
    pix_valid = 0; pix_sof = 0;
    check({tag, "_frame_valid"}, frame_valid, 1);
    check({tag, "_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_frame_valid_single"}, frame_valid, 0);
    check({tag, "_busy_wait"}, busy, 1);
  endtask

  initial begin
    // Reset values while held in reset.
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_frame_zero", frame_out[31:0], 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("ready_after_release", pix_ready, 1);

    // Frame A: pixel k = k, sof on the first.
    for (int k = 0; k < NPIX; k++) send_pix(PIX_W'(k), k == 0);
    expect_launch("A");
    check("A_byte0", frame_out[7:0], 8'd0);
    check("A_byte77", frame_out[8*77 +: 8], 8'd77);
    check("A_byte143", frame_out[8*143 +: 8], 8'd143);

    // Pixels offered during WAIT are ignored.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix_in = 8'hFF; pix_valid = 1;
    end
    check("wait_pix_ready", pix_ready, 0);
    check("wait_frame_kept", frame_out[8*5 +: 8], 8'd5);
    pulse_done();
    check("done_ready_rises", pix_ready, 1);
    check("done_busy_low", busy, 0);

    // Frame B: no sof, value 3k+1.
    for (int k = 0; k < NPIX; k++) send_pix(PIX_W'(3 * k + 1), 1'b0);
    expect_launch("B");
    check("B_byte0", frame_out[7:0], 8'd1);
    check("B_byte143", frame_out[8*143 +: 8], 8'd174);
    pulse_done();

    // cnn_done in FILL flags err but does not disturb the pixel count.
    for (int k = 0; k < 10; k++) send_pix(PIX_W'(8'h10 + k), k == 0);
    pulse_done();
    check("fill_done_err", err, 1);
    for (int k = 0; k < NPIX - 10; k++) send_pix(PIX_W'(8'h20 + k), 1'b0);
    expect_launch("C");
    check("C_byte9", frame_out[8*9 +: 8], 8'h19);
    check("C_byte10", frame_out[8*10 +: 8], 8'h20);

    // Asynchronous reset in the middle of WAIT.
    idle(3);
    @(negedge clk);
    #2 rst = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_err", err, 0);
    check("async_ready", pix_ready, 0);
    check("async_frame_valid", frame_valid, 0);
    check("async_frame", frame_out[8*10 +: 8], 8'h00);
    idle(2);
    rst = 1;

    // Partial frame of 50, then sof restarts the frame and flags err.
    for (int k = 0; k < 50; k++) send_pix(PIX_W'(8'h30 + k), 1'b0);
    @(negedge clk);
    check("partial_no_err", err, 0);
    pix_in = 8'hAA; pix_valid = 1; pix_sof = 1;
    for (int k = 1; k < NPIX - 1; k++) send_pix(PIX_W'(8'h40 + k), 1'b0);
    check("sof_err", err, 1);
    check("sof_byte0", frame_out[7:0], 8'hAA);
    check("no_launch_at_142", busy, 0);
    send_pix(PIX_W'(8'h40 + NPIX - 1), 1'b0);
    expect_launch("D");
    check("D_byte1", frame_out[8*1 +: 8], 8'h41);
    check("D_byte143", frame_out[8*143 +: 8], 8'hCF);
    pulse_done();

    // No cnn_done after a launch.
    @(negedge clk);
    rst = 0;
    idle(2);
    rst = 1;
    for (int k = 0; k < NPIX; k++) send_pix(PIX_W'(k ^ 8'h5A), k == 0);
    expect_launch("E");
`ifdef IMG_FRAME_LOADER_WDOG_EN
    idle(15);
    check("wdog_still_busy", busy, 1);
    check("wdog_no_err_yet", err, 0);
    idle(1);
    check("wdog_busy_low", busy, 0);
    check("wdog_err", err, 1);
    check("wdog_ready", pix_ready, 1);
`else
    idle(1000);
    check("nowdog_busy", busy, 1);
    check("nowdog_err", err, 0);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/img_frame_loader.md
IMG_FRAME_LOADER -- requirements
Module: img_frame_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter NPIX, default 144, pixels per frame (12x12).
REQ-003 SHALL have parameter WDOG_CYCLES, default 4096, max cycles waiting for cnn_done.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pix_in  in  PIX_W  pixel data.
REQ-007 SHALL have port pix_valid  in  1  pixel present.
REQ-008 SHALL have port pix_sof  in  1  marks the accepted pixel as pixel 0 of a frame.
REQ-009 SHALL have port pix_ready  out  1  loader can accept a pixel.
REQ-010 SHALL have port frame_out  out  PIX_W*NPIX  assembled frame for CNN input_img_source.
REQ-011 SHALL have port frame_valid  out  1  one-cycle launch pulse to CNN valid.
REQ-012 SHALL have port cnn_done  in  1  CNN result-ready pulse (top-level ready).
REQ-013 SHALL have port busy  out  1  frame launched, result not yet returned.
REQ-014 SHALL have port err  out  1  sticky error flag.

Function
REQ-015 SHALL implement states FILL, LAUNCH, WAIT; reset state FILL.
REQ-016 Pixel SHALL be accepted only in a cycle with pix_valid=1 and pix_ready=1; pix_ready=1 only in FILL.
REQ-017 Accepted pixel k (0-based) SHALL be written to frame_out[PIX_W*k +: PIX_W]; index counter increments by 1 per accepted pixel.
REQ-018 Accepted pixel with pix_sof=1 SHALL be written at index 0 and the counter set to 1; if the counter was nonzero, err SHALL be set (partial frame discarded, prior bits not cleared).
REQ-019 Accepted pixel with pix_sof=0 while counter=0 SHALL be accepted as pixel 0 (sof optional at frame start).
REQ-020 Acceptance of pixel NPIX-1 SHALL move FILL->LAUNCH next cycle; counter wraps to 0.
REQ-021 LAUNCH SHALL last exactly one cycle with frame_valid=1, then move to WAIT; latency last pixel accepted -> frame_valid = 1 cycle.
REQ-022 frame_out SHALL be stable from LAUNCH until WAIT exits.
REQ-023 busy SHALL be 1 in LAUNCH and WAIT, else 0.
REQ-024 In WAIT, cnn_done=1 SHALL move to FILL next cycle; pix_ready rises that cycle.
REQ-025 cnn_done in FILL or LAUNCH SHALL be ignored and set err.
REQ-026 pix_valid in LAUNCH/WAIT SHALL be ignored (no acceptance, no error).

Reset
REQ-027 rst=0 SHALL immediately force state FILL, counter 0, frame_out 0, frame_valid 0, pix_ready 0 until first clock after release then 1, busy 0, err 0.
REQ-028 Reset during LAUNCH or WAIT SHALL abandon the frame; no frame_valid after release without a full new frame.
REQ-029 err SHALL clear only on reset.

Configuration
REQ-030 With IMG_FRAME_LOADER_WDOG_EN defined, a WAIT cycle counter SHALL run; reaching WDOG_CYCLES without cnn_done SHALL set err and move to FILL with counter 0.
REQ-031 Without IMG_FRAME_LOADER_WDOG_EN, WAIT SHALL persist indefinitely until cnn_done or reset; no watchdog counter logic present.

Verification
REQ-032 Stream 144 pixels value k (k=0..143), sof on first -> frame_out byte k = k, frame_valid single pulse 1 cycle after pixel 143, busy=1.
REQ-033 In WAIT drive pix_valid=1 for 20 cycles, then cnn_done pulse -> no pixel accepted, pix_ready=1 the cycle after cnn_done, second frame loads correctly.
REQ-034 Send 50 pixels, then sof pixel 0xAA -> err=1, byte 0 = 0xAA, launch after 143 further pixels.
REQ-035 Assert rst=0 mid-WAIT -> all outputs reset asynchronously; a full 144-pixel frame is needed for next frame_valid.
REQ-036 WDOG_EN defined, WDOG_CYCLES=16, no cnn_done -> err=1 and FILL after 16 WAIT cycles; undefined -> busy stays 1 for 1000 cycles.
REQ-037 Pulse cnn_done in FILL -> err=1, frame counter unaffected.
